// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem read, a single held instruction
// for decode, and redirects that can land in any state while discarding stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  input  logic        PCSrc,
  input  logic [31:0] pc_target
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t      state;
  logic [31:0] pc_reg;
  logic        drop;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc_reg <= word_align(RESET_PC);
      instr  <= NOP;
      drop   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          // A response still owed to an abandoned grant may arrive here; it only clears drop.
          if (imem_rvalid) drop <= 1'b0;
          if (PCSrc) begin
            pc_reg <= word_align(pc_target);
            if (imem_gnt) drop <= 1'b1;
          end else if (imem_gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (PCSrc) begin
            pc_reg <= word_align(pc_target);
            if (imem_rvalid) begin
              state <= FETCH;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FETCH;
            end else begin
              instr <= imem_rdata;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Redirect outranks consumption so the target wins over pc+4.
          if (PCSrc) begin
            pc_reg <= word_align(pc_target);
            state  <= FETCH;
          end else if (instr_ready) begin
            pc_reg <= pc_reg + 32'd4;
            state  <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc_reg;
  assign instr_valid = (state == HOLD) && !rst;
  assign pc          = pc_reg;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, redirects, wrap and reset.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, imem_gnt, imem_rvalid, instr_ready, PCSrc;
  logic [31:0] imem_rdata, pc_target;
  logic        imem_req, instr_valid, funct7;
  logic [31:0] imem_addr, instr, pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        w_req, w_valid, w_funct7;
  logic [31:0] w_addr, w_instr, w_pc;
  logic [6:0]  w_op;
  logic [2:0]  w_funct3;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .pc(pc), .op(op), .funct3(funct3),
    .funct7(funct7), .PCSrc(PCSrc), .pc_target(pc_target)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(w_valid),
    .instr_ready(instr_ready), .instr(w_instr), .pc(w_pc), .op(w_op), .funct3(w_funct3),
    .funct7(w_funct7), .PCSrc(PCSrc), .pc_target(pc_target)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; PCSrc = 1'b0; pc_target = 32'h0;
    repeat (3) cyc();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", pc); end
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_rel_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_rel_addr got %h exp 00000000", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h00A0_0093; words[1] = 32'h0010_8113; words[2] = 32'h0020_8193;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d] got %0h exp 1", i, imem_req); end
      checks++; if (imem_addr !== 32'(i * 4)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 32'(i * 4)); end
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL seq_wait_req[%0d] got %0h exp 0", i, imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_wait_valid[%0d] got %0h exp 0", i, instr_valid); end
      imem_rvalid = 1'b1; imem_rdata = words[i];
      cyc();
      imem_rvalid = 1'b0;
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %0h exp 1", i, instr_valid); end
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, 32'(i * 4)); end
      checks++; if (instr !== words[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, instr, words[i]); end
      cyc();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_drop_valid[%0d] got %0h exp 0", i, instr_valid); end
    end
    checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_next_addr got %h exp 0000000c", imem_addr); end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h40B5_0533;
    cyc();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0h exp 1", k, instr_valid); end
      checks++; if (instr !== 32'h40B5_0533) begin errors++; $display("FAIL bp_instr[%0d] got %h exp 40b50533", k, instr); end
      checks++; if (pc !== 32'hC) begin errors++; $display("FAIL bp_pc[%0d] got %h exp 0000000c", k, pc); end
      checks++; if (op !== 7'h33) begin errors++; $display("FAIL bp_op[%0d] got %h exp 33", k, op); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req[%0d] got %0h exp 0", k, imem_req); end
      cyc();
    end
    checks++; if (funct3 !== 3'd0) begin errors++; $display("FAIL bp_funct3 got %0d exp 0", funct3); end
    checks++; if (funct7 !== 1'b1) begin errors++; $display("FAIL bp_funct7 got %0h exp 1", funct7); end
    instr_ready = 1'b1;
    cyc();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got %0h exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL bp_after_req got req=%0h addr=%h exp req=1 addr=00000010", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; PCSrc = 1'b1; pc_target = 32'h0000_0103;
    cyc();
    PCSrc = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rw_req got %0h exp 0", imem_req); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rw_valid got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h40B5_0533) begin errors++; $display("FAIL rw_instr got %h exp 40b50533", instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL rw_addr got req=%0h addr=%h exp req=1 addr=00000100", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_fetch();
    imem_gnt = 1'b1; PCSrc = 1'b1; pc_target = 32'h200;
    cyc();
    imem_gnt = 1'b0; PCSrc = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL rf_addr got req=%0h addr=%h exp req=1 addr=00000200", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rf_stale_valid got %0h exp 0", instr_valid); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0020_A023;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rf_valid got %0h exp 1", instr_valid); end
    checks++; if (pc !== 32'h200 || instr !== 32'h0020_A023) begin
      errors++; $display("FAIL rf_word got pc=%h instr=%h exp pc=00000200 instr=0020a023", pc, instr); end
    checks++; if (funct3 !== 3'd2 || op !== 7'h23) begin
      errors++; $display("FAIL rf_fields got funct3=%0d op=%h exp funct3=2 op=23", funct3, op); end
    cyc();
  endtask

  task automatic test_redirect_consume();
    PCSrc = 1'b1; pc_target = 32'h8;
    cyc();
    PCSrc = 1'b0;
    checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL rc_pc8 got %h exp 00000008", imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h8) begin
      errors++; $display("FAIL rc_hold got valid=%0h pc=%h exp valid=1 pc=00000008", instr_valid, pc); end
    instr_ready = 1'b1; PCSrc = 1'b1; pc_target = 32'h40;
    cyc();
    PCSrc = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rc_valid got %0h exp 0", instr_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL rc_addr got req=%0h addr=%h exp req=1 addr=00000040", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    checks++; if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_start got req=%0h addr=%h exp req=1 addr=fffffffc", w_req, w_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013;
    cyc();
    imem_rvalid = 1'b0;
    checks++; if (w_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_hold got valid=%0h pc=%h exp valid=1 pc=fffffffc", w_valid, w_pc); end
    instr_ready = 1'b1;
    cyc();
    checks++; if (w_req !== 1'b1 || w_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_addr got req=%0h addr=%h exp req=1 addr=00000000", w_req, w_addr); end
  endtask

  task automatic test_reset_mid_wait();
    checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL rmw_pre_addr got %h exp 00000004", imem_addr); end
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0; rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmw_rst_req got %0h exp 0", imem_req); end
    cyc();
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL rmw_addr got req=%0h addr=%h exp req=1 addr=00000000", imem_req, imem_addr); end
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    cyc();
    imem_rvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rmw_valid[%0d] got %0h exp 0", k, instr_valid); end
      checks++; if (instr !== 32'h13) begin errors++; $display("FAIL rmw_instr[%0d] got %h exp 00000013", k, instr); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
        errors++; $display("FAIL rmw_req[%0d] got req=%0h addr=%h exp req=1 addr=00000000", k, imem_req, imem_addr); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_fetch();
    test_redirect_consume();
    test_wrap();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset; bits [1:0] SHALL be treated as 0.

Interface
REQ-002 SHALL have clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have imem_req, output, 1: instruction-memory read request.
REQ-005 SHALL have imem_addr, output, 32: read address; word-aligned; stable while imem_req=1.
REQ-006 SHALL have imem_gnt, input, 1: memory accepts the request in any cycle where imem_req=1 and imem_gnt=1.
REQ-007 SHALL have imem_rvalid, input, 1: read data valid; occurs at least 1 cycle after the grant; at most one read is outstanding.
REQ-008 SHALL have imem_rdata, input, 32: instruction word, sampled when imem_rvalid=1.
REQ-009 SHALL have instr_valid, output, 1: an instruction is presented to decode.
REQ-010 SHALL have instr_ready, input, 1: decode consumes the instruction when instr_valid=1 and instr_ready=1.
REQ-011 SHALL have instr, output, 32: the held instruction word.
REQ-012 SHALL have pc, output, 32: address of the presented instruction.
REQ-013 SHALL have op, output, 7, equal to instr[6:0]; funct3, output, 3, equal to instr[14:12]; funct7, output, 1, equal to instr[30].
REQ-014 SHALL have PCSrc, input, 1: redirect request from control.
REQ-015 SHALL have pc_target, input, 32: redirect address, sampled when PCSrc=1.

Function
REQ-016 SHALL implement three states: FETCH, WAIT and HOLD.
REQ-017 In FETCH, SHALL drive imem_req=1 and imem_addr=pc_reg; on imem_gnt=1 SHALL go to WAIT, otherwise SHALL stay in FETCH.
REQ-018 In WAIT, SHALL drive imem_req=0; on imem_rvalid=1 SHALL register imem_rdata into instr and go to HOLD.
REQ-019 In HOLD, SHALL drive instr_valid=1, with instr and pc held stable until consumed.
REQ-020 On consumption (instr_valid=1 and instr_ready=1), SHALL set pc_reg to pc_reg+4 and go to FETCH; instr_valid SHALL be 0 in the next cycle.
REQ-021 PC increments SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 SHALL give 32'h0000_0000.
REQ-022 Latency SHALL be: grant at cycle N, rvalid at cycle M (M>N), instr_valid=1 at cycle M+1; consumption at cycle K gives the next imem_req at cycle K+1.
REQ-023 On PCSrc=1 in any state, SHALL set pc_reg to {pc_target[31:2],2'b00}.
REQ-024 Redirect in FETCH: SHALL go to FETCH; the current request SHALL be abandoned even if imem_gnt=1 in the same cycle, with a drop flag set so the response to that grant is discarded.
REQ-025 Redirect in WAIT: SHALL set the drop flag and stay in WAIT; the next imem_rvalid SHALL be discarded, the drop flag cleared, and the state SHALL go to FETCH.
REQ-026 Redirect in HOLD: SHALL drop instr_valid next cycle and go to FETCH.
REQ-027 Redirect and consumption in the same cycle: the redirect SHALL win, giving pc_reg = target, not pc+4.
REQ-028 SHALL never present a discarded word on instr_valid.
REQ-029 instr_valid SHALL be 0 whenever the state is not HOLD.

Reset
REQ-030 While rst=1, SHALL drive imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), pc_reg=RESET_PC and drop flag=0, and SHALL force the state to FETCH.
REQ-031 A reset asserted mid-operation SHALL abandon any outstanding read; the first imem_rvalid after reset is released with no post-reset grant SHALL be ignored.
REQ-032 imem_req=1 with imem_addr=RESET_PC SHALL appear in the first cycle after rst falls.

Verification
REQ-033 Sequential fetch: gnt immediate, rvalid 1 cycle later, ready always 1 -> imem_addr sequence 0, 4, 8, and instr_valid pulses with matching pc.
REQ-034 Backpressure: instr_ready=0 for 5 cycles -> instr, pc and op stay constant; no imem_req until consumed.
REQ-035 Redirect in WAIT: PCSrc=1 with pc_target=32'h0000_0103 -> stale rvalid is not presented; next imem_addr=32'h0000_0100.
REQ-036 Redirect and consumption in the same cycle: pc=8, PCSrc=1, pc_target=32'h40 -> next imem_addr=32'h40, not 32'hC.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFFC, consume one instruction -> next imem_addr=32'h0.
REQ-038 Reset mid-WAIT: rst pulsed, then a late rvalid arrives -> instr_valid stays 0; imem_addr=RESET_PC; decode sees instr=32'h13.
